keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  4x4 matrix keypad scanner; feeds onehot2binary directly with a debounced 16-bit one-hot key code.
//  - Drives rows low one at a time and samples the active-low columns through a 2-flop synchroniser.
//  - Assembles a full 16-key snapshot per scan, then debounces across consecutive scans.
//  - Publishes a single stable one-hot key code plus a one-cycle press strobe.
// PARAMETERS
//  SCAN_DIV        default 1000  clk cycles each row is held active (>=2)
//  DEBOUNCE_SCANS  default 4     consecutive identical snapshots required before accepting (>=1)
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  col        in   4   keypad columns, active-low, externally pulled up, asynchronous
//  row        out  4   keypad row drive, active-low, exactly one bit low at all times
//  onehot     out  16  debounced key code: bit (r*4+c) = key at row r / col c; 0 = no key
//  key_press  out  1   one-cycle pulse when onehot takes a new nonzero value
// BEHAVIOUR
//  Reset values:
//  - row=4'b1110; onehot=0; key_press=0.
//  - Synchroniser regs=4'b1111; div/row/debounce counters=0; snapshot and previous snapshot=0.
//  Row sequencer, states ROW0->ROW1->ROW2->ROW3->ROW0:
//  - row ROWn drives bit n low.
//  - div counter runs 0..SCAN_DIV-1 per row; the state advances when it wraps.
//  - Column sample uses the synchronised col, taken on div==SCAN_DIV-1.
//    Snapshot bits [n*4+3:n*4] = ~col_sync.
//  - Scan complete = the sample cycle of ROW3. Scan period = 4*SCAN_DIV cycles.
//  Debounce, evaluated on each scan complete with new snapshot S:
//  - S != previous snapshot -> stable count=0.
//  - S == previous snapshot -> stable count saturating increment.
//  - previous snapshot <= S.
//  - Accept when the stable count reaches DEBOUNCE_SCANS-1 (DEBOUNCE_SCANS=1 accepts every scan).
//  On accept:
//  - popcount(S)==0 -> release (see CONFIGURATION).
//  - popcount(S)==1 -> onehot<=S on the next clk.
//  - popcount(S)>=2 (ghost/multi-key) -> ignored; onehot holds its value.
//  key_press:
//  - Asserted for exactly one cycle, in the same cycle onehot is loaded with a nonzero value different
//    from its prior value.
//  - Re-accepting the same held key gives no pulse.
//  - Press->release->press of the same key pulses again, provided onehot returned to 0 in between.
//  Boundaries:
//  - col changing mid-row is seen only at the sample point.
//  - Counters wrap without overflow: div width $clog2(SCAN_DIV); stable count saturates.
//  - rst mid-scan returns everything to reset values on the next clk; no key_press is emitted.
//  Latency: key stable from scan k -> onehot valid 1 cycle after scan k+DEBOUNCE_SCANS-1 completes.
// CONFIGURATION
//  KEY_HOLD_EN defined:
//  - An accepted all-zero snapshot leaves onehot unchanged; the last key is held until another key is
//    accepted.
//  - key_press still fires only on a changed nonzero value.
//  KEY_HOLD_EN undefined:
//  - An accepted all-zero snapshot clears onehot to 0.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan period 16 cycles)
//  1. rst high 2 cycles, then low.
//     -> row=1110, onehot=0, key_press=0.
//     -> row steps 1101/1011/0111/1110 every 4 cycles.
//  2. Hold key r1,c2 (col=1011 while row=1101) for 3 full scans.
//     -> onehot=16'h0040 one cycle after the 3rd scan completes; single key_press pulse.
//  3. Key r1,c2 bounces (present alternate scans) for 6 scans, then stable 3 scans.
//     -> no update during bounce; onehot=16'h0040 after the 3rd stable scan.
//  4. Hold r0,c3 and r2,c1 together for 5 scans.
//     -> onehot unchanged, no key_press.
//  5. Release after case 2 for 3 scans.
//     -> onehot=0 (KEY_HOLD_EN undefined) / stays 16'h0040 (KEY_HOLD_EN defined).
//     -> no key_press in either build.
//  6. Assert rst during ROW2 with a key held 2 scans.
//     -> outputs return to reset values next clk; onehot needs a full 3 scans after rst falls.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with scan-level debounce and one-hot key output.
// Define KEY_HOLD_EN to keep the last accepted key on release instead of clearing it.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] onehot,
  output logic        key_press
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    ROW3 = 2'd3
  } row_state_e;

  row_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [11:0]      snap_q, snap_d;
  logic [15:0]      prev_q, prev_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [15:0]      onehot_q, onehot_d;
  logic             key_press_q, key_press_d;

  logic             scan_done;
  logic             accept;
  logic [15:0]      scan_snap;
  logic [4:0]       scan_pop;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Row 3 columns are folded in directly on the completing cycle rather than stored first.
  assign scan_snap = {~sync2_q, snap_q};
  assign scan_pop  = popcount16(scan_snap);

  always_comb begin
    sync1_d     = col;
    sync2_d     = sync1_q;
    div_d       = div_q + DIV_W'(1);
    state_d     = state_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    onehot_d    = onehot_q;
    key_press_d = 1'b0;
    scan_done   = 1'b0;
    accept      = 1'b0;

    if (div_q == DIV_LAST) begin
      div_d = '0;
      unique case (state_q)
        ROW0: begin snap_d[3:0]  = ~sync2_q; state_d = ROW1; end
        ROW1: begin snap_d[7:4]  = ~sync2_q; state_d = ROW2; end
        ROW2: begin snap_d[11:8] = ~sync2_q; state_d = ROW3; end
        ROW3: begin scan_done    = 1'b1;     state_d = ROW0; end
      endcase
    end

    if (scan_done) begin
      if (scan_snap != prev_q) begin
        stable_d = '0;
      end else if (stable_q != CNT_ACCEPT) begin
        stable_d = stable_q + CNT_W'(1);
      end
      prev_d = scan_snap;
      accept = (stable_d == CNT_ACCEPT);
    end

    if (accept) begin
      if (scan_pop == 5'd1) begin
        onehot_d    = scan_snap;
        key_press_d = (scan_snap != onehot_q);
      end else if (scan_pop == 5'd0) begin
`ifdef KEY_HOLD_EN
        onehot_d = onehot_q;
`else
        onehot_d = '0;
`endif
      end
    end
  end

  always_comb begin
    row = 4'b1110;
    unique case (state_q)
      ROW0: row = 4'b1110;
      ROW1: row = 4'b1101;
      ROW2: row = 4'b1011;
      ROW3: row = 4'b0111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ROW0;
      div_q       <= '0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      snap_q      <= '0;
      prev_q      <= '0;
      stable_q    <= '0;
      onehot_q    <= '0;
      key_press_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      onehot_q    <= onehot_d;
      key_press_q <= key_press_d;
    end
  end

  assign onehot    = onehot_q;
  assign key_press = key_press_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=3, 16-cycle scans).
module tb_keypad_scan;

  logic        clk;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] onehot;
  logic        key_press;

  logic [15:0] keys;
  int unsigned tests_run;
  int unsigned tests_failed;
  int unsigned press_cnt;
  int unsigned press_base;
  logic [15:0] rel_val;

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .onehot    (onehot),
    .key_press (key_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && key_press) press_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scans(input int n);
    repeat (16 * n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    press_cnt    = 0;
    keys         = '0;
`ifdef KEY_HOLD_EN
    rel_val = 16'h0040;
`else
    rel_val = 16'h0000;
`endif

    // 1: reset and row sequencing
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_row", {28'd0, row}, 32'h0000_000e);
    check("rst_onehot", {16'd0, onehot}, 32'd0);
    check("rst_press", {31'd0, key_press}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1; check("row_step1", {28'd0, row}, 32'h0000_000d);
    repeat (4) @(posedge clk); #1; check("row_step2", {28'd0, row}, 32'h0000_000b);
    repeat (4) @(posedge clk); #1; check("row_step3", {28'd0, row}, 32'h0000_0007);
    repeat (4) @(posedge clk); #1; check("row_step0", {28'd0, row}, 32'h0000_000e);

    // 2: single key r1,c2 held
    keys = 16'h0040;
    press_base = press_cnt;
    scans(2);
    check("hold_pre", {16'd0, onehot}, 32'd0);
    scans(1);
    check("hold_onehot", {16'd0, onehot}, 32'h0000_0040);
    check("hold_press", {31'd0, key_press}, 32'd1);
    scans(1);
    check("hold_reaccept", {16'd0, onehot}, 32'h0000_0040);
    check("hold_pulses", press_cnt - press_base, 32'd1);

    // 5: release
    keys = '0;
    press_base = press_cnt;
    scans(2);
    check("rel_pre", {16'd0, onehot}, 32'h0000_0040);
    scans(1);
    check("rel_onehot", {16'd0, onehot}, {16'd0, rel_val});
    check("rel_press", {31'd0, key_press}, 32'd0);
    scans(1);
    check("rel_pulses", press_cnt - press_base, 32'd0);

    // 3: bounce then stable
    press_base = press_cnt;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      scans(1);
      check("bounce_hold", {16'd0, onehot}, {16'd0, rel_val});
    end
    keys = 16'h0040;
    scans(2);
    check("stable_pre", {16'd0, onehot}, {16'd0, rel_val});
    scans(1);
    check("stable_onehot", {16'd0, onehot}, 32'h0000_0040);
    check("stable_press", {31'd0, key_press}, {31'd0, (rel_val != 16'h0040)});
    scans(1);
    check("stable_pulses", press_cnt - press_base, (rel_val != 16'h0040) ? 32'd1 : 32'd0);

    // 4: two keys together are ignored
    keys = 16'h0208;
    press_base = press_cnt;
    for (int i = 0; i < 5; i++) begin
      scans(1);
      check("multi_hold", {16'd0, onehot}, 32'h0000_0040);
    end
    scans(1);
    check("multi_pulses", press_cnt - press_base, 32'd0);

    // 6: reset mid-scan during ROW2 with key r3,c1 held two scans
    keys = 16'h2000;
    scans(2);
    check("pre_rst_onehot", {16'd0, onehot}, 32'h0000_0040);
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_row", {28'd0, row}, 32'h0000_000b);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_row", {28'd0, row}, 32'h0000_000e);
    check("mid_rst_onehot", {16'd0, onehot}, 32'd0);
    check("mid_rst_press", {31'd0, key_press}, 32'd0);
    rst = 1'b0;
    scans(2);
    check("post_rst_pre", {16'd0, onehot}, 32'd0);
    scans(1);
    check("post_rst_onehot", {16'd0, onehot}, 32'h0000_2000);
    check("post_rst_press", {31'd0, key_press}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
